// File: rtl/display_pkg.sv
// Shared types and limits for the display request arbiter.
package display_pkg;

    localparam int NUM_REQ_MAX = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        HOLD = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first active request after the last winner, with wrap.
module rr_priority_picker #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any_req
);

    always_comb begin
        int unsigned cand;
        cand    = 0;
        grant   = '0;
        idx     = '0;
        any_req = 1'b0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            cand = (32'(last) + off) % NUM_REQ;
            if (!any_req && req[cand]) begin
                any_req     = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/display_request_arbiter.sv
// Round-robin arbiter sharing the 7-segment output driver, with a registered
// output stage and a minimum on-display hold that error requests may cut short.
module display_request_arbiter
    import display_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_REQ     = 3,
    parameter int HOLD_CYCLES = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
    input  logic [NUM_REQ-1:0]            i_req_error,
    input  logic [NUM_REQ-1:0]            i_req_is_neg,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    output logic [NUM_REQ-1:0]            o_req_ready,
    output logic [DATA_WIDTH-1:0]         o_data,
    output logic                          o_error,
    output logic                          o_data_is_neg,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [$clog2(NUM_REQ)-1:0]    o_grant_idx
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

    if (NUM_REQ < 2 || NUM_REQ > NUM_REQ_MAX) begin : g_bad_num_req
        $fatal(1, "display_request_arbiter: NUM_REQ must be 2..8");
    end
    if (DATA_WIDTH % 4 != 0) begin : g_bad_data_width
        $fatal(1, "display_request_arbiter: DATA_WIDTH must be a multiple of 4");
    end

    arb_state_e          state;
    arb_state_e          state_nxt;
    logic [IDX_W-1:0]    last;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [NUM_REQ-1:0]  pick_grant;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_any;
    logic                accept;
    logic                err_pre;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req     (i_req_valid),
        .last    (last),
        .grant   (pick_grant),
        .idx     (pick_idx),
        .any_req (pick_any)
    );

    // Ready is suppressed during reset so no producer sees a handshake that is then lost.
    assign accept  = (state == IDLE) && !rst && pick_any;
    assign err_pre = |(i_req_valid & i_req_error);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE: state_nxt = accept ? SEND : IDLE;
            SEND: begin
                if (!i_ready) begin
                    state_nxt = SEND;
                end else if (HOLD_CYCLES == 0) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = HOLD;
                end
            end
            HOLD: state_nxt = (err_pre || hold_cnt == '0) ? IDLE : HOLD;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_req_ready = '0;
        o_valid     = 1'b0;
        case (state)
            IDLE:    if (!rst) o_req_ready = pick_grant;
            SEND:    o_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_data        <= '0;
            o_error       <= 1'b0;
            o_data_is_neg <= 1'b0;
            o_grant_idx   <= '0;
            last          <= IDX_W'(NUM_REQ - 1);
        end else if (accept) begin
            o_data        <= i_req_data[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
            o_error       <= i_req_error[pick_idx];
            o_data_is_neg <= i_req_is_neg[pick_idx];
            o_grant_idx   <= pick_idx;
            last          <= pick_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt <= '0;
        end else if (state == SEND && i_ready) begin
            hold_cnt <= HOLD_LOAD;
        end else if (state == HOLD && hold_cnt != '0) begin
            hold_cnt <= hold_cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_display_request_arbiter.sv
// Scoreboard bench for display_request_arbiter (3 requesters, hold 4) plus a no-hold instance.
module tb_display_request_arbiter;

    typedef struct {
        logic [15:0] data;
        logic        err;
        logic        neg;
        logic [1:0]  idx;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [47:0] req_data;
    logic [2:0]  req_error;
    logic [2:0]  req_neg;
    logic [2:0]  req_valid;
    logic [2:0]  o_req_ready;
    logic [15:0] o_data;
    logic        o_error;
    logic        o_neg;
    logic        o_valid;
    logic        rdy;
    logic [1:0]  o_grant_idx;

    logic [47:0] z_data;
    logic [2:0]  z_valid;
    logic [2:0]  z_ready;
    logic [15:0] z_o_data;
    logic        z_o_error;
    logic        z_o_neg;
    logic        z_o_valid;
    logic        z_rdy;
    logic [1:0]  z_grant_idx;

    int n_checks = 0;
    int n_pass   = 0;
    exp_t sb[$];
    int   m_last = 2;
    int   mk;
    exp_t me;

    display_request_arbiter #(
        .DATA_WIDTH  (16),
        .NUM_REQ     (3),
        .HOLD_CYCLES (4)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .i_req_data    (req_data),
        .i_req_error   (req_error),
        .i_req_is_neg  (req_neg),
        .i_req_valid   (req_valid),
        .o_req_ready   (o_req_ready),
        .o_data        (o_data),
        .o_error       (o_error),
        .o_data_is_neg (o_neg),
        .o_valid       (o_valid),
        .i_ready       (rdy),
        .o_grant_idx   (o_grant_idx)
    );

    display_request_arbiter #(
        .DATA_WIDTH  (16),
        .NUM_REQ     (3),
        .HOLD_CYCLES (0)
    ) u_dut_nohold (
        .clk           (clk),
        .rst           (rst),
        .i_req_data    (z_data),
        .i_req_error   (3'b000),
        .i_req_is_neg  (3'b000),
        .i_req_valid   (z_valid),
        .o_req_ready   (z_ready),
        .o_data        (z_o_data),
        .o_error       (z_o_error),
        .o_data_is_neg (z_o_neg),
        .o_valid       (z_o_valid),
        .i_ready       (z_rdy),
        .o_grant_idx   (z_grant_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int rr_pick(input logic [2:0] v, input int last);
        for (int off = 1; off <= 3; off++) begin
            int c;
            c = (last + off) % 3;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    // Scoreboard: push on a grant, pop on a downstream handshake.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            m_last = 2;
        end else begin
            if (o_req_ready !== 3'b000) begin
                mk = rr_pick(req_valid, m_last);
                n_checks++;
                if (mk < 0 || o_req_ready !== (3'b001 << mk)) begin
                    $display("FAIL grant_pick: o_req_ready=%b valid=%b expected pick=%0d", o_req_ready, req_valid, mk);
                end else begin
                    n_pass++;
                    me.data = req_data[mk*16 +: 16];
                    me.err  = req_error[mk];
                    me.neg  = req_neg[mk];
                    me.idx  = 2'(mk);
                    sb.push_back(me);
                    m_last = mk;
                end
            end
            if (o_valid === 1'b1 && rdy === 1'b1) begin
                n_checks++;
                if (sb.size() == 0) begin
                    $display("FAIL sb_unexpected: handshake with o_data=%h but no grant pending", o_data);
                end else begin
                    n_pass++;
                    me = sb.pop_front();
                    n_checks++;
                    if (o_data !== me.data) $display("FAIL sb_data: got %h expected %h", o_data, me.data);
                    else n_pass++;
                    n_checks++;
                    if (o_error !== me.err) $display("FAIL sb_error: got %b expected %b", o_error, me.err);
                    else n_pass++;
                    n_checks++;
                    if (o_neg !== me.neg) $display("FAIL sb_neg: got %b expected %b", o_neg, me.neg);
                    else n_pass++;
                    n_checks++;
                    if (o_grant_idx !== me.idx) $display("FAIL sb_idx: got %0d expected %0d", o_grant_idx, me.idx);
                    else n_pass++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (o_valid !== 1'b0) $display("FAIL rst_valid: got %b expected 0", o_valid); else n_pass++;
        n_checks++; if (o_data !== 16'h0) $display("FAIL rst_data: got %h expected 0000", o_data); else n_pass++;
        n_checks++; if (o_error !== 1'b0) $display("FAIL rst_error: got %b expected 0", o_error); else n_pass++;
        n_checks++; if (o_neg !== 1'b0) $display("FAIL rst_neg: got %b expected 0", o_neg); else n_pass++;
        n_checks++; if (o_req_ready !== 3'b000) $display("FAIL rst_ready: got %b expected 000", o_req_ready); else n_pass++;
        n_checks++; if (o_grant_idx !== 2'd0) $display("FAIL rst_idx: got %0d expected 0", o_grant_idx); else n_pass++;
        n_checks++; if (z_o_valid !== 1'b0) $display("FAIL rst_nohold_valid: got %b expected 0", z_o_valid); else n_pass++;
    endtask

    task automatic test_single();
        step();
        req_data[31:16] = 16'h00A5;
        req_valid = 3'b010;
        rdy = 1'b1;
        @(negedge clk);
        n_checks++; if (o_req_ready !== 3'b010) $display("FAIL single_ready: got %b expected 010", o_req_ready); else n_pass++;
        step();
        @(negedge clk);
        n_checks++; if (o_valid !== 1'b1) $display("FAIL single_valid: got %b expected 1", o_valid); else n_pass++;
        n_checks++; if (o_data !== 16'h00A5) $display("FAIL single_data: got %h expected 00a5", o_data); else n_pass++;
        n_checks++; if (o_grant_idx !== 2'd1) $display("FAIL single_idx: got %0d expected 1", o_grant_idx); else n_pass++;
        for (int i = 2; i <= 5; i++) begin
            step();
            @(negedge clk);
            n_checks++; if (o_valid !== 1'b0) $display("FAIL hold_valid_c%0d: got %b expected 0", i, o_valid); else n_pass++;
            n_checks++; if (o_req_ready !== 3'b000) $display("FAIL hold_ready_c%0d: got %b expected 000", i, o_req_ready); else n_pass++;
        end
        step();
        @(negedge clk);
        n_checks++; if (o_req_ready !== 3'b010) $display("FAIL hold_release: got %b expected 010 six cycles after accept", o_req_ready); else n_pass++;
        step();
        req_valid = 3'b000;
        idle(8);
    endtask

    task automatic test_round_robin();
        int got;
        logic [1:0]  got_idx [4];
        logic [15:0] got_dat [4];
        logic [15:0] rr_dat [3];
        int exp_order [4];
        exp_order = '{0, 1, 2, 0};
        rr_dat = '{16'h1111, 16'h2222, 16'h3333};
        got = 0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        req_data = {rr_dat[2], rr_dat[1], rr_dat[0]};
        req_neg = 3'b010;
        req_error = 3'b000;
        req_valid = 3'b111;
        rdy = 1'b1;
        for (int cyc = 0; cyc < 60 && got < 4; cyc++) begin
            @(negedge clk);
            if (o_valid === 1'b1) begin
                got_idx[got] = o_grant_idx;
                got_dat[got] = o_data;
                got++;
            end
        end
        step();
        req_valid = 3'b000;
        n_checks++; if (got != 4) $display("FAIL rr_timeout: got %0d handshakes expected 4", got); else n_pass++;
        for (int i = 0; i < got; i++) begin
            n_checks++;
            if (got_idx[i] !== 2'(exp_order[i])) $display("FAIL rr_order_%0d: got %0d expected %0d", i, got_idx[i], exp_order[i]);
            else n_pass++;
            n_checks++;
            if (got_dat[i] !== rr_dat[exp_order[i]]) $display("FAIL rr_data_%0d: got %h expected %h", i, got_dat[i], rr_dat[exp_order[i]]);
            else n_pass++;
        end
        req_neg = 3'b000;
        idle(8);
    endtask

    task automatic test_backpressure();
        req_data[15:0] = 16'h1234;
        req_valid = 3'b001;
        rdy = 1'b0;
        @(negedge clk);
        n_checks++; if (o_req_ready !== 3'b001) $display("FAIL bp_ready: got %b expected 001", o_req_ready); else n_pass++;
        step();
        req_valid = 3'b010;
        req_data[31:16] = 16'h5555;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++; if (o_valid !== 1'b1) $display("FAIL bp_valid_%0d: got %b expected 1", i, o_valid); else n_pass++;
            n_checks++; if (o_data !== 16'h1234) $display("FAIL bp_data_%0d: got %h expected 1234", i, o_data); else n_pass++;
            n_checks++; if (o_req_ready !== 3'b000) $display("FAIL bp_noready_%0d: got %b expected 000", i, o_req_ready); else n_pass++;
            step();
        end
        rdy = 1'b1;
        req_valid = 3'b000;
        @(negedge clk);
        n_checks++; if (o_valid !== 1'b1) $display("FAIL bp_before_hs: got %b expected 1", o_valid); else n_pass++;
        step();
        @(negedge clk);
        n_checks++; if (o_valid !== 1'b0) $display("FAIL bp_after_hs: got %b expected 0", o_valid); else n_pass++;
        idle(8);
    endtask

    task automatic test_error_preempt();
        req_data[15:0] = 16'h0042;
        req_valid = 3'b001;
        req_error = 3'b000;
        rdy = 1'b1;
        @(negedge clk);
        n_checks++; if (o_req_ready !== 3'b001) $display("FAIL ep_first_ready: got %b expected 001", o_req_ready); else n_pass++;
        step();
        req_valid = 3'b000;
        step();
        step();
        req_valid = 3'b100;
        req_error = 3'b100;
        req_data[47:32] = 16'hEEEE;
        @(negedge clk);
        n_checks++; if (o_req_ready !== 3'b000) $display("FAIL ep_in_hold: got %b expected 000", o_req_ready); else n_pass++;
        step();
        @(negedge clk);
        n_checks++; if (o_req_ready !== 3'b100) $display("FAIL ep_preempt_ready: got %b expected 100", o_req_ready); else n_pass++;
        step();
        req_valid = 3'b000;
        req_error = 3'b000;
        @(negedge clk);
        n_checks++; if (o_valid !== 1'b1) $display("FAIL ep_valid: got %b expected 1", o_valid); else n_pass++;
        n_checks++; if (o_error !== 1'b1) $display("FAIL ep_error: got %b expected 1", o_error); else n_pass++;
        n_checks++; if (o_grant_idx !== 2'd2) $display("FAIL ep_idx: got %0d expected 2", o_grant_idx); else n_pass++;
        idle(8);
    endtask

    task automatic test_reset_mid_send();
        req_data[31:16] = 16'h0BAD;
        req_valid = 3'b010;
        rdy = 1'b0;
        @(negedge clk);
        n_checks++; if (o_req_ready !== 3'b010) $display("FAIL rms_ready: got %b expected 010", o_req_ready); else n_pass++;
        step();
        req_valid = 3'b000;
        @(negedge clk);
        n_checks++; if (o_valid !== 1'b1) $display("FAIL rms_send: got %b expected 1", o_valid); else n_pass++;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (o_valid !== 1'b0) $display("FAIL rms_valid: got %b expected 0", o_valid); else n_pass++;
        n_checks++; if (o_req_ready !== 3'b000) $display("FAIL rms_noready: got %b expected 000", o_req_ready); else n_pass++;
        step();
        req_data = {16'hC003, 16'hB002, 16'hA001};
        req_valid = 3'b111;
        rdy = 1'b1;
        @(negedge clk);
        n_checks++; if (o_req_ready !== 3'b001) $display("FAIL rms_ptr_reset: got %b expected 001", o_req_ready); else n_pass++;
        step();
        req_valid = 3'b000;
        @(negedge clk);
        n_checks++; if (o_grant_idx !== 2'd0) $display("FAIL rms_idx: got %0d expected 0", o_grant_idx); else n_pass++;
        idle(8);
    endtask

    task automatic test_no_hold();
        int pulses;
        logic exp_v;
        pulses = 0;
        z_data[15:0] = 16'h0F0F;
        z_valid = 3'b001;
        z_rdy = 1'b1;
        @(negedge clk);
        n_checks++; if (z_ready !== 3'b001) $display("FAIL nh_ready: got %b expected 001", z_ready); else n_pass++;
        for (int k = 1; k <= 8; k++) begin
            step();
            @(negedge clk);
            exp_v = (k % 2 == 1);
            n_checks++;
            if (z_o_valid !== exp_v) $display("FAIL nh_valid_c%0d: got %b expected %b", k, z_o_valid, exp_v);
            else n_pass++;
            if (z_o_valid === 1'b1) begin
                pulses++;
                n_checks++;
                if (z_o_data !== 16'h0F0F) $display("FAIL nh_data_c%0d: got %h expected 0f0f", k, z_o_data);
                else n_pass++;
            end
        end
        step();
        z_valid = 3'b000;
        n_checks++; if (pulses != 4) $display("FAIL nh_pulses: got %0d expected 4", pulses); else n_pass++;
        idle(4);
    endtask

    initial begin
        rst = 1'b1;
        req_data = '0;
        req_error = '0;
        req_neg = '0;
        req_valid = '0;
        rdy = 1'b0;
        z_data = '0;
        z_valid = '0;
        z_rdy = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_error_preempt();
        test_reset_mid_send();
        test_no_hold();
        n_checks++;
        if (sb.size() != 0) $display("FAIL sb_drain: %0d entries left expected 0", sb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
